mole_round_scheduler: RTL and testbench

- Sequences whack-a-mole rounds: picks a pseudo-random hole, lights it for a timed window and judges the player's key press.
- Produces the per-round hit flag and round-end strobe consumed by the score counter (W / timeUp).
- Sits between the game-state FSM, which supplies `enable`, and the score counter, LEDs and keys.

---
 rtl/mole_pkg.sv | 20 ++
 rtl/mole_lfsr.sv | 22 ++
 rtl/mole_round_scheduler.sv | 159 +++++++++++++++
 tb/tb_mole_round_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round scheduler and its LFSR.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SHOW,
    RESULT
  } state_e;

  localparam int                LFSR_W       = 8;
  // Galois form of x^8+x^6+x^5+x^4+1, right-shifting.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

  function automatic int idx_width(input int num_holes);
    return $clog2(num_holes);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Galois LFSR that steps only when advance is high; reusable random source.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (advance) begin
      value <= {1'b0, value[LFSR_W-1:1]} ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/mole_round_scheduler.sv
// Picks a non-repeating random hole, lights it for a timed window and judges the
// player's key press, emitting a registered hit flag and a one-cycle round_done.
module mole_round_scheduler
  import mole_pkg::*;
#(
  parameter int                NUM_HOLES  = 4,
  parameter int                SHOW_TICKS = 8,
  parameter int                GAP_TICKS  = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = DEFAULT_SEED
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 tick,
  input  logic [NUM_HOLES-1:0] keys,
  output logic [NUM_HOLES-1:0] moles,
  output logic                 hit,
  output logic                 round_done,
  output logic [7:0]           round_count
);

  localparam int                   IDX_W = idx_width(NUM_HOLES);
  localparam logic [NUM_HOLES-1:0] HOLE0 = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [NUM_HOLES-1:0] keys_q;
  logic [NUM_HOLES-1:0] moles_q, moles_d;
  logic [IDX_W-1:0]     prev_idx_q, prev_idx_d;
  logic                 hit_q, hit_d;
  logic                 done_q, done_d;
  logic [7:0]           count_q, count_d;

  logic [LFSR_W-1:0]    lfsr;
  logic [IDX_W-1:0]     cand, pick;
  logic [NUM_HOLES-1:0] kedge, idx_mask;
  logic                 key_right, key_wrong, last_tick;
  logic [7:0]           count_inc;
  logic                 unused_lfsr_hi;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clock   (Clock),
    .reset   (reset),
    .advance (enable),
    .value   (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:IDX_W];

  // Bump the candidate past the previous hole so no hole lights twice in a row.
  assign cand      = lfsr[IDX_W-1:0];
  assign pick      = (cand == prev_idx_q) ? cand + IDX_W'(1) : cand;

  // In SHOW, prev_idx_q is the hole currently lit.
  assign kedge     = keys & ~keys_q;
  assign idx_mask  = HOLE0 << prev_idx_q;
  assign key_right = |(kedge & idx_mask);
  assign key_wrong = |(kedge & ~idx_mask);
  assign last_tick = tick && (cnt_q == 8'd1);
  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    moles_d    = moles_q;
    prev_idx_d = prev_idx_q;
    hit_d      = hit_q;
    done_d     = 1'b0;
    count_d    = count_q;

    case (state_q)
      IDLE: begin
        moles_d = '0;
        if (enable) begin
          state_d = GAP;
          cnt_d   = 8'(GAP_TICKS);
        end
      end

      GAP: begin
        moles_d = '0;
        if (!enable) begin
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_q == 8'd1) begin
            state_d    = SHOW;
            prev_idx_d = pick;
            moles_d    = HOLE0 << pick;
            cnt_d      = 8'(SHOW_TICKS);
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      SHOW: begin
        if (!enable) begin
          state_d = IDLE;
          moles_d = '0;
        end else if (key_wrong || key_right || last_tick) begin
          // A wrong key beats a simultaneous right key; a key beats the final tick.
          state_d = RESULT;
          moles_d = '0;
          done_d  = 1'b1;
          hit_d   = key_right && !key_wrong;
          count_d = count_inc;
        end else if (tick) begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      RESULT: begin
        moles_d = '0;
        if (enable) begin
          state_d = GAP;
          cnt_d   = 8'(GAP_TICKS);
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        moles_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      keys_q     <= '0;
      moles_q    <= '0;
      prev_idx_q <= '0;
      hit_q      <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      keys_q     <= keys;
      moles_q    <= moles_d;
      prev_idx_q <= prev_idx_d;
      hit_q      <= hit_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end

  assign moles       = moles_q;
  assign hit         = hit_q;
  assign round_done  = done_q;
  assign round_count = count_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler: round outcomes, priorities, enable drop,
// async reset mid-round and round_count saturation with no repeated holes.
module tb_mole_round_scheduler;

  logic       Clock;
  logic       reset;
  logic       enable;
  logic       tick;
  logic [3:0] keys;
  logic [3:0] moles;
  logic       hit;
  logic       round_done;
  logic [7:0] round_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] m_lfsr;
  logic [1:0] m_prev;
  logic [1:0] exp_idx;
  logic [7:0] exp_count;
  logic       cur_hit;

  mole_round_scheduler #(
    .NUM_HOLES  (4),
    .SHOW_TICKS (8),
    .GAP_TICKS  (2),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .Clock       (Clock),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .keys        (keys),
    .moles       (moles),
    .hit         (hit),
    .round_done  (round_done),
    .round_count (round_count)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic [7:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 8'b1011_1000;
    return s;
  endfunction

  function automatic logic [1:0] model_pick(input logic [7:0] l, input logic [1:0] p);
    logic [1:0] c;
    c = l[1:0];
    return (c == p) ? c + 2'd1 : c;
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Reference LFSR stepping alongside the design while enable is high.
  always @(posedge Clock or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else if (enable) m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  // From GAP with a full count: two ticks, then the predicted hole must light.
  task automatic show_mole();
    tick = 1'b1; cyc(); tick = 1'b0;
    check("gap_dark", 32'(moles), 32'(0));
    cyc();
    exp_idx = model_pick(m_lfsr, m_prev);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("mole_lit", 32'(moles), 32'(oh(exp_idx)));
    check("no_repeat", 32'(moles & oh(m_prev)), 32'(0));
    m_prev = exp_idx;
  endtask

  // Called right after the judging edge: RESULT cycle, then back in GAP.
  task automatic finish_round(input logic exp_hit);
    if (exp_count != 8'hFF) exp_count++;
    cur_hit = exp_hit;
    check("done_high", 32'(round_done), 32'(1));
    check("hit_result", 32'(hit), 32'(exp_hit));
    check("result_dark", 32'(moles), 32'(0));
    check("round_count", 32'(round_count), 32'(exp_count));
    cyc();
    check("done_low", 32'(round_done), 32'(0));
    check("hit_stable", 32'(hit), 32'(exp_hit));
  endtask

  task automatic press(input logic [3:0] k, input logic exp_hit);
    keys = k; cyc(); keys = 4'b0;
    finish_round(exp_hit);
  endtask

  // Run the full show window; last_keys are raised together with the final tick.
  task automatic timeout_round(input logic [3:0] last_keys, input logic exp_hit);
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1;
      if (i == 7) keys = keys | last_keys;
      cyc();
      tick = 1'b0;
      if (i < 7) begin
        check("show_hold", 32'(moles), 32'(oh(m_prev)));
        cyc();
      end
    end
    keys = 4'b0;
    finish_round(exp_hit);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tick = 1'b0; keys = 4'b0;
    m_prev = 2'd0; exp_count = 8'd0; cur_hit = 1'b0; exp_idx = 2'd0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_moles", 32'(moles), 32'(0));
    check("rst_hit", 32'(hit), 32'(0));
    check("rst_done", 32'(round_done), 32'(0));
    check("rst_count", 32'(round_count), 32'(0));
    check("rst_lfsr", 32'(dut.u_lfsr.value), 32'(8'hA5));
    reset = 1'b0;
    cyc();
    check("idle_dark", 32'(moles), 32'(0));
    check("idle_lfsr_hold", 32'(dut.u_lfsr.value), 32'(8'hA5));
    enable = 1'b1;
    cyc();
    check("enter_gap", 32'(moles), 32'(0));

    show_mole(); press(oh(m_prev), 1'b1);                       // correct key
    show_mole(); timeout_round(4'b0, 1'b0);                     // no key
    show_mole(); press(oh(m_prev), 1'b1);
    keys = 4'hF; show_mole(); timeout_round(4'b0, 1'b0);        // held into SHOW
    show_mole(); press(oh(m_prev), 1'b1);
    show_mole(); press(oh(m_prev + 2'd1), 1'b0);                // wrong key
    show_mole(); press(oh(m_prev), 1'b1);
    show_mole(); press(oh(m_prev) | oh(m_prev + 2'd1), 1'b0);   // right+wrong
    show_mole(); timeout_round(oh(m_prev), 1'b1);               // key on final tick

    // Enable drops mid-SHOW: silent abort back to IDLE.
    show_mole();
    tick = 1'b1; cyc(); tick = 1'b0;
    enable = 1'b0;
    cyc();
    check("abort_dark", 32'(moles), 32'(0));
    check("abort_no_done", 32'(round_done), 32'(0));
    check("abort_hit", 32'(hit), 32'(cur_hit));
    check("abort_count", 32'(round_count), 32'(exp_count));
    cyc();
    check("abort_idle_done", 32'(round_done), 32'(0));
    check("abort_idle_dark", 32'(moles), 32'(0));
    enable = 1'b1;
    cyc();

    // Async reset mid-SHOW, observed without a clock edge.
    show_mole();
    reset = 1'b1;
    #1;
    check("amid_moles", 32'(moles), 32'(0));
    check("amid_hit", 32'(hit), 32'(0));
    check("amid_done", 32'(round_done), 32'(0));
    check("amid_count", 32'(round_count), 32'(0));
    check("amid_lfsr", 32'(dut.u_lfsr.value), 32'(8'hA5));
    @(posedge Clock);
    #1;
    reset = 1'b0;
    m_prev = 2'd0; exp_count = 8'd0; cur_hit = 1'b0;
    cyc();

    for (int r = 0; r < 300; r++) begin
      show_mole();
      if ($urandom_range(0, 1) == 1) press(oh(m_prev), 1'b1);
      else press(oh(m_prev + 2'd2), 1'b0);
    end
    check("count_saturated", 32'(round_count), 32'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
